// File: rtl/dbnc_pkg.sv
// Shared event types and constants for the scanned switch debouncer.
package dbnc_pkg;

  localparam int EVT_CH_W  = 4;
  localparam int EVT_REC_W = 2 + EVT_CH_W;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2
  } evt_code_t;

  typedef struct packed {
    evt_code_t             code;
    logic [EVT_CH_W-1:0]   ch;
  } evt_rec_t;

  // All-ones reload value for a counter of the given width (up to 32 bits).
  function automatic logic [31:0] cnt_reload(input int bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
  endfunction

endpackage

// File: rtl/dbnc_evt_fifo.sv
// Small synchronous event FIFO; a push on full is accepted only when a pop frees a slot that cycle.
module dbnc_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data_in,
  input  logic         pop,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign data_out  = r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dbnc_scan_ctrl.sv
// Round-robin debouncer: one shared down-counter datapath services one switch channel per clock.
// Long-press detection (LONG events) is compiled in only when DBNC_LONGPRESS_EN is defined.
module dbnc_scan_ctrl #(
  parameter int N_SW       = 4,
  parameter int CNT_BITS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_BITS  = 24
) (
  input  logic                     clk50m,
  input  logic                     rst,
  input  logic [N_SW-1:0]          sw,
  input  logic                     ovf_clr,
  output logic [N_SW-1:0]          sw_dbnc,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_code,
  output logic [$clog2(N_SW)-1:0]  evt_ch,
  output logic                     evt_ovf
);

  import dbnc_pkg::*;

  localparam int                  CH_W       = $clog2(N_SW);
  localparam logic [CNT_BITS-1:0] CNT_RELOAD = CNT_BITS'(cnt_reload(CNT_BITS));
  localparam logic [CH_W-1:0]     PTR_LAST   = CH_W'(N_SW - 1);

  if (N_SW < 2 || N_SW > 16 || FIFO_DEPTH < 2 || HOLD_BITS < 1) begin : g_param_check
    $error("dbnc_scan_ctrl: unsupported parameter set");
  end

  logic [N_SW-1:0]     r_sync1, r_sync2, r_stable;
  logic [CNT_BITS-1:0] r_cnt [N_SW];
  logic [CH_W-1:0]     r_ptr;
  logic                r_ovf;

  logic                 w_s, w_stable, w_stable_next;
  logic [CNT_BITS-1:0]  w_cnt, w_cnt_next;
  logic                 w_push, w_pop, w_drop, w_full, w_empty;
  evt_rec_t             w_push_rec, w_head;
  logic [EVT_REC_W-1:0] w_head_bits;
  logic                 w_unused_head_bits;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_ptr   <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      r_ptr   <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign w_s      = r_sync2[r_ptr];
  assign w_stable = r_stable[r_ptr];
  assign w_cnt    = r_cnt[r_ptr];

`ifdef DBNC_LONGPRESS_EN
  localparam logic [HOLD_BITS-1:0] HOLD_MAX = '1;

  logic [HOLD_BITS-1:0] r_hold [N_SW];
  logic [N_SW-1:0]      r_long_done;
  logic [HOLD_BITS-1:0] w_hold, w_hold_next;
  logic                 w_long_done, w_long_done_next;

  assign w_hold      = r_hold[r_ptr];
  assign w_long_done = r_long_done[r_ptr];

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_long_done <= '0;
      for (int i = 0; i < N_SW; i++) r_hold[i] <= '0;
    end else begin
      r_hold[r_ptr]      <= w_hold_next;
      r_long_done[r_ptr] <= w_long_done_next;
    end
  end
`endif

  // A mismatch decrements; reaching 1 on a mismatch means D consecutive mismatches, so accept.
  always_comb begin
    w_cnt_next      = CNT_RELOAD;
    w_stable_next   = w_stable;
    w_push          = 1'b0;
    w_push_rec.code = PRESS;
    w_push_rec.ch   = EVT_CH_W'(r_ptr);
`ifdef DBNC_LONGPRESS_EN
    w_hold_next      = w_hold;
    w_long_done_next = w_long_done;
`endif
    if (w_s != w_stable) begin
      if (w_cnt == CNT_BITS'(1)) begin
        w_stable_next   = w_s;
        w_push          = 1'b1;
        w_push_rec.code = w_s ? PRESS : RELEASE;
`ifdef DBNC_LONGPRESS_EN
        if (!w_s) begin
          w_hold_next      = '0;
          w_long_done_next = 1'b0;
        end
`endif
      end else begin
        w_cnt_next = w_cnt - 1'b1;
      end
    end
`ifdef DBNC_LONGPRESS_EN
    else if (w_s) begin
      if (w_hold != HOLD_MAX) w_hold_next = w_hold + 1'b1;
      if (w_hold_next == HOLD_MAX && !w_long_done) begin
        w_push           = 1'b1;
        w_push_rec.code  = LONG;
        w_long_done_next = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < N_SW; i++) r_cnt[i] <= CNT_RELOAD;
    end else begin
      r_stable[r_ptr] <= w_stable_next;
      r_cnt[r_ptr]    <= w_cnt_next;
    end
  end

  assign w_pop  = !w_empty && evt_ready;
  assign w_drop = w_push && w_full && !w_pop;

  dbnc_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_REC_W)
  ) u_evt_fifo (
    .clk      (clk50m),
    .rst      (rst),
    .push     (w_push),
    .data_in  (w_push_rec),
    .pop      (w_pop),
    .data_out (w_head_bits),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_head             = evt_rec_t'(w_head_bits);
  assign w_unused_head_bits = &{1'b0, w_head.ch};

  // Set has priority over clear so a drop in the clearing cycle is still reported.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign sw_dbnc   = r_stable;
  assign evt_valid = !w_empty;
  assign evt_code  = w_empty ? 2'b00 : w_head.code;
  assign evt_ch    = w_empty ? '0 : w_head.ch[CH_W-1:0];
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_dbnc_scan_ctrl.sv
// Randomized and directed bench for dbnc_scan_ctrl against a run-length/queue reference model.
// Build with DBNC_LONGPRESS_EN to also exercise LONG events.
module tb_dbnc_scan_ctrl;

  localparam int N_SW       = 4;
  localparam int CNT_BITS   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_BITS  = 5;
  localparam int D          = (1 << CNT_BITS) - 1;
  localparam int HMAX       = (1 << HOLD_BITS) - 1;
  localparam int CH_W       = $clog2(N_SW);

  logic              clk50m    = 1'b0;
  logic              rst       = 1'b1;
  logic [N_SW-1:0]   sw        = '0;
  logic              ovf_clr   = 1'b0;
  logic              evt_ready = 1'b0;
  logic [N_SW-1:0]   sw_dbnc;
  logic              evt_valid;
  logic [1:0]        evt_code;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_ovf;

  always #10 clk50m = ~clk50m;

  dbnc_scan_ctrl #(
    .N_SW       (N_SW),
    .CNT_BITS   (CNT_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_BITS  (HOLD_BITS)
  ) dut (
    .clk50m    (clk50m),
    .rst       (rst),
    .sw        (sw),
    .ovf_clr   (ovf_clr),
    .sw_dbnc   (sw_dbnc),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ch    (evt_ch),
    .evt_ovf   (evt_ovf)
  );

  // Reference model: per-channel run length of consecutive mismatching services plus an event queue.
  logic [N_SW-1:0] m_d1, m_d2, m_stable;
  int m_run  [N_SW];
  int m_hold [N_SW];
  bit m_ld   [N_SW];
  int m_qcode[$];
  int m_qch  [$];
  int m_cyc;
  bit m_ovf;
  int n_fullpp;

  int n_checks = 0;
  int n_fail   = 0;
  int log_ch[$];
  int log_code[$];
  int dut_long = 0;
  int valid_cycles = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  c;
    bit  s, have, pop, full_before;
    int  ecode;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0;
      for (int i = 0; i < N_SW; i++) begin
        m_run[i] = 0; m_hold[i] = 0; m_ld[i] = 0;
      end
      m_qcode.delete(); m_qch.delete();
      m_cyc = 0; m_ovf = 0;
      return;
    end
    c = m_cyc % N_SW;
    s = m_d2[c];
    have = 0; ecode = 0;
    if (s != m_stable[c]) begin
      m_run[c]++;
      if (m_run[c] == D) begin
        m_stable[c] = s;
        m_run[c] = 0;
        have = 1;
        ecode = s ? 0 : 1;
`ifdef DBNC_LONGPRESS_EN
        if (!s) begin
          m_hold[c] = 0;
          m_ld[c] = 0;
        end
`endif
      end
    end else begin
      m_run[c] = 0;
`ifdef DBNC_LONGPRESS_EN
      if (s) begin
        if (m_hold[c] < HMAX) m_hold[c]++;
        if (m_hold[c] == HMAX && !m_ld[c]) begin
          have = 1; ecode = 2; m_ld[c] = 1;
        end
      end
`endif
    end
    full_before = (m_qch.size() == FIFO_DEPTH);
    pop = (m_qch.size() != 0) && evt_ready;
    if (pop) begin
      void'(m_qch.pop_front());
      void'(m_qcode.pop_front());
    end
    if (have && m_qch.size() < FIFO_DEPTH) begin
      m_qch.push_back(c);
      m_qcode.push_back(ecode);
      if (pop && full_before) n_fullpp++;
    end
    if (have && m_qch.size() >= FIFO_DEPTH && !(pop && full_before) && full_before) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_d2 = m_d1;
    m_d1 = sw;
    m_cyc++;
  endtask

  function automatic bit push_next();
    int c;
    c = m_cyc % N_SW;
    return (m_d2[c] != m_stable[c]) && (m_run[c] == D - 1);
  endfunction

  task automatic compare_all();
    check("sw_dbnc", int'(sw_dbnc), int'(m_stable));
    check("evt_valid", int'(evt_valid), int'(m_qch.size() != 0));
    check("evt_ovf", int'(evt_ovf), int'(m_ovf));
    if (m_qch.size() != 0) begin
      check("evt_code", int'(evt_code), m_qcode[0]);
      check("evt_ch", int'(evt_ch), m_qch[0]);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      if (!rst && evt_valid && evt_ready) begin
        log_ch.push_back(int'(evt_ch));
        log_code.push_back(int'(evt_code));
        if (evt_code == 2'd2) dut_long++;
        $display("event pop: ch=%0d code=%0d t=%0t", evt_ch, evt_code, $time);
      end
      if (!rst && evt_valid) valid_cycles++;
      @(posedge clk50m);
      model_edge();
      @(negedge clk50m);
      compare_all();
    end
  endtask

  initial begin
    int lat, n0, fpp0;
    bit hit;
    n_fullpp = 0;

    // Reset state
    step(3);
    check("rst_evt_code", int'(evt_code), 0);
    check("rst_evt_ch", int'(evt_ch), 0);
    check("rst_sw_dbnc", int'(sw_dbnc), 0);

    // Idle with all switches low
    rst = 1'b0; evt_ready = 1'b1; valid_cycles = 0;
    step(100);
    check("idle_valid_cycles", valid_cycles, 0);

    // Clean rise on channel 2
    sw[2] = 1'b1; lat = 0;
    while (!sw_dbnc[2] && lat < 60) begin
      step(1);
      lat++;
    end
    check("ch2_latency_in_window", int'(lat >= 27 && lat <= 33), 1);
    step(3);
    check("ch2_pop_count", log_ch.size(), 1);
    check("ch2_pop_ch", log_ch[log_ch.size()-1], 2);
    check("ch2_pop_code", log_code[log_code.size()-1], 0);

    // Channel 1 bouncing every 5 cycles, then settling high
    n0 = log_ch.size();
    for (int i = 0; i < 40; i++) begin
      sw[1] = ~sw[1];
      step(5);
    end
    check("bounce_quiet", log_ch.size() - n0, 0);
    sw[1] = 1'b1;
    step(45);
    check("bounce_one_event", log_ch.size() - n0, 1);
    check("bounce_ch", log_ch[log_ch.size()-1], 1);
    check("bounce_code", log_code[log_code.size()-1], 0);

    // All channels rise together with the consumer stalled
    sw = '0;
    step(40);
    evt_ready = 1'b0;
    while ((m_cyc + 2) % N_SW != 0) step(1);
    sw = '1;
    step(40);
    check("full_head_ch", int'(evt_ch), 0);
    check("full_no_ovf", int'(evt_ovf), 0);
    sw[0] = 1'b0;
    step(40);
    check("drop_sets_ovf", int'(evt_ovf), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr_clears", int'(evt_ovf), 0);
    n0 = log_ch.size();
    evt_ready = 1'b1;
    step(8);
    check("drain_count", log_ch.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order_ch", log_ch[n0+i], i);
      check("drain_order_code", log_code[n0+i], 0);
    end

    // Push and pop on the same cycle while full
    evt_ready = 1'b0;
    sw = 4'b0001;
    step(40);
    sw[1] = 1'b1;
    hit = 0; fpp0 = n_fullpp;
    for (int k = 0; k < 80 && !hit; k++) begin
      if (m_qch.size() == FIFO_DEPTH && push_next()) begin
        evt_ready = 1'b1; hit = 1;
      end else begin
        evt_ready = 1'b0;
      end
      step(1);
    end
    evt_ready = 1'b0;
    check("pp_coincide", n_fullpp - fpp0, 1);
    check("pp_no_drop", int'(evt_ovf), 0);
    evt_ready = 1'b1;
    step(10);

    // Reset mid-debounce with events queued
    evt_ready = 1'b0;
    sw = 4'b1010;
    step(35);
    rst = 1'b1;
    step(2);
    check("rst_mid_valid", int'(evt_valid), 0);
    check("rst_mid_dbnc", int'(sw_dbnc), 0);
    rst = 1'b0; evt_ready = 1'b1;
    step(50);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) sw = N_SW'($urandom);
      if ($urandom_range(0, 14) == 0) sw[$urandom_range(0, N_SW-1)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      step(1);
    end
    ovf_clr = 1'b0;

`ifdef DBNC_LONGPRESS_EN
    // Long press on channel 3
    rst = 1'b1; sw = '0;
    step(2);
    rst = 1'b0; evt_ready = 1'b1;
    step(10);
    n0 = dut_long;
    sw = 4'b1000;
    step(200);
    check("long_first", dut_long - n0, 1);
    step(150);
    check("long_no_repeat", dut_long - n0, 1);
    sw = '0;
    step(40);
    sw = 4'b1000;
    step(200);
    check("long_second", dut_long - n0, 2);
    sw = '0;
    step(40);
    sw = 4'b1000;
    step(80);
    rst = 1'b1;
    step(2);
    check("long_rst_valid", int'(evt_valid), 0);
    rst = 1'b0;
    step(60);
`else
    check("no_long_code", dut_long, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbnc_scan_ctrl.md
# dbnc_scan_ctrl

Time-multiplexed debounce controller for a bank of mechanical switches. A single round-robin scheduler shares one compare/decrement datapath across all channels, servicing one channel per clock. It holds per-channel state in a register array and emits press/release events through a valid/ready event queue. It sits between the raw board switch pins and the user-interface logic, and replaces per-switch debouncer instances.

## Interface
- N_SW, 4: number of switch channels (2..16)
- CNT_BITS, 16: debounce counter width; debounce length D = 2^CNT_BITS-1 services
- FIFO_DEPTH, 4: event queue depth (power of two, ≥2)
- HOLD_BITS, 24: long-press hold counter width (used only with the long-press macro)
- clk50m  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sw  input  N_SW  raw switch levels, asynchronous to clk50m
- ovf_clr  input  1  clears evt_ovf
- sw_dbnc  output  N_SW  debounced stable levels
- evt_valid  output  1  event available at queue head
- evt_ready  input  1  consumer accepts head event
- evt_code  output  2  event type from dbnc_pkg: 0 PRESS, 1 RELEASE, 2 LONG
- evt_ch  output  $clog2(N_SW)  channel index of the head event
- evt_ovf  output  1  sticky flag: an event was dropped because the queue was full

## Operation
- Each sw bit passes through a 2-FF synchronizer; the reset value of each stage is 0.
- Scheduler pointer ptr steps 0,1,…,N_SW-1,0 every cycle, with no idle states. Each channel is serviced once every N_SW cycles.
- Per-channel state: stable level, cnt[CNT_BITS-1:0] and, under the macro, hold[HOLD_BITS-1:0] plus a long_done bit.
- Service of channel c, where s is the synchronized input:
  - If s == stable: cnt reloads to all ones.
  - If s != stable and cnt != 1: cnt decrements by 1.
  - If s != stable and cnt == 1: stable becomes s and cnt reloads to all ones. The block pushes PRESS when s=1, or RELEASE when s=0.
- The datapath never reaches cnt==0. A level must mismatch on D consecutive services to be accepted. Any matching service restarts the count.
- sw_dbnc[c] = stable[c].
- At most one push per cycle, because only one channel is serviced per cycle.
- Event queue:
  - Pop when evt_valid && evt_ready.
  - Push when full without a simultaneous pop: the event is dropped and evt_ovf is set.
  - Push on full with a simultaneous pop: both happen and nothing is lost.
  - Push on empty: the event becomes visible next cycle.
- evt_ovf:
  - Cleared by ovf_clr.
  - When a set and ovf_clr occur in the same cycle, set wins.
- Reset values:
  - sw_dbnc = 0, stable = 0, all cnt = all ones, ptr = 0.
  - Queue empty, evt_valid = 0, evt_code = 0, evt_ch = 0, evt_ovf = 0.
  - hold = 0, long_done = 0.
- Reset asserted mid-debounce or with events queued discards all in-progress counts and queued events. No event is generated on reset release. Switches held at release are reported as PRESS after D services.

## Timing
- Input edge to synchronized s: 2 cycles.
- Accepting service at edge t: sw_dbnc[c] changes after edge t, and the push is registered at edge t.
- If the queue was empty, evt_valid is high from edge t until the pop edge.
- Worst-case detection latency: 2 + N_SW·D cycles after the input settles.
- evt_code and evt_ch stay stable while evt_valid && !evt_ready.

## Configuration
- DBNC_LONGPRESS_EN defined:
  - While stable=1 and s=1, hold increments on each service and saturates at all ones.
  - On reaching all ones with long_done=0, the block pushes LONG and sets long_done.
  - A RELEASE clears hold and long_done.
  - LONG and debounce events of the same channel can never coincide, because one service produces at most one push. An accepting edge takes priority.
- DBNC_LONGPRESS_EN undefined:
  - No hold counters or long_done logic.
  - Code 2 is never produced.
  - The HOLD_BITS parameter is ignored.

## Structure
- Package dbnc_pkg contains:
  - the evt_code_t enum (PRESS, RELEASE, LONG);
  - the event record struct {code, ch};
  - the CNT_RELOAD all-ones constant helper.
- Sub-module dbnc_evt_fifo is a synchronous FIFO with parameterized depth. Its ports are push, data_in, pop, data_out, full, empty. It is instantiated once.
- Top level contains the synchronizers, the scheduler pointer, the state arrays, the shared service datapath and the overflow flag.

## Test plan
All scenarios use N_SW=4, CNT_BITS=3 (D=7), FIFO_DEPTH=4 and HOLD_BITS=5, unless stated otherwise.
- Reset then idle 100 cycles with sw=0: sw_dbnc=0, evt_valid never high.
- Channel 2 steps 0→1 cleanly: sw_dbnc[2] rises exactly 2+7·4 cycles (±3, depending on pointer phase) after the edge. The event is {PRESS, 2}, accepted with evt_ready=1.
- Channel 1 bounces 0/1 every 5 cycles for 200 cycles, then holds 1: no event during the bounce, then exactly one PRESS ch1.
- All 4 channels rise simultaneously with evt_ready=0: 4 events are queued in order ch0..ch3 and evt_ovf stays 0. A fifth event (ch0 release) is dropped and sets evt_ovf. ovf_clr clears it.
- Queue full while a push and pop happen on the same cycle: no drop, evt_ovf stays 0, order is preserved.
- Build with DBNC_LONGPRESS_EN, hold channel 3 high: one PRESS, then LONG after 31 further services, with no repeat. Releasing gives RELEASE, and holding again gives a second LONG. Asserting rst mid-hold clears everything with no event.
